// File: rtl/logic_chain_pkg.sv
// logic_chain_pkg
//   Shared definitions for the pipelined logic-chain datapath:
//   - WIN          : depth of the node window carried between stages
//   - chain_op_e   : boolean operator applied at a recurrence node
//   - node_op      : operator for node k (k mod 3 -> AND / XOR / OR)
//   - num_stages   : number of recurrence groups (pipeline stages)
//   - group_first  : first node index of a group
//   - group_count  : node count of a group (the last group may be short)
package logic_chain_pkg;

  // The newest five nodes cover both the k-4 recurrence tap and the
  // n_{L-4} term used by y4.
  localparam int WIN = 5;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_XOR = 2'd1,
    OP_OR  = 2'd2
  } chain_op_e;

  function automatic chain_op_e node_op(input int k);
    case (k % 3)
      1:       return OP_AND;
      2:       return OP_XOR;
      default: return OP_OR;
    endcase
  endfunction

  // Nodes 10..L split into groups of nodes_per_stage, rounded up.
  function automatic int num_stages(input int chain_len, input int nodes_per_stage);
    return (chain_len - 9 + nodes_per_stage - 1) / nodes_per_stage;
  endfunction

  function automatic int group_first(input int nodes_per_stage, input int s);
    return 10 + s * nodes_per_stage;
  endfunction

  function automatic int group_count(input int chain_len, input int nodes_per_stage,
                                     input int s);
    int rem;
    rem = chain_len - group_first(nodes_per_stage, s) + 1;
    return (rem < nodes_per_stage) ? rem : nodes_per_stage;
  endfunction

endpackage

// File: rtl/logic_chain_stage.sv
// logic_chain_stage
//   Purely combinational slice of the node recurrence. Takes the window of
//   the five newest nodes (index 0 oldest, index WIN-1 newest) and extends
//   the chain by NODE_COUNT nodes starting at index FIRST_NODE, returning
//   the five newest nodes afterwards.
//   Ports:
//     prev_win  in   WIN x W  window ending at node FIRST_NODE-1
//     next_win  out  WIN x W  window ending at node FIRST_NODE+NODE_COUNT-1
module logic_chain_stage
  import logic_chain_pkg::*;
#(
  parameter int W          = 1,
  parameter int FIRST_NODE = 10,
  parameter int NODE_COUNT = 7
) (
  input  logic [WIN-1:0][W-1:0] prev_win,
  output logic [WIN-1:0][W-1:0] next_win
);

  // node[m] for m < WIN mirrors the incoming window; node[WIN+m] is
  // chain node FIRST_NODE+m. Tap k-1 sits one slot back, tap k-4 four back.
  logic [W-1:0] node [WIN+NODE_COUNT];

  always_comb begin
    for (int m = 0; m < WIN; m++) begin
      node[m] = prev_win[m];
    end
    for (int m = 0; m < NODE_COUNT; m++) begin
      case (node_op(FIRST_NODE + m))
        OP_AND:  node[WIN+m] = node[WIN+m-1] & node[WIN+m-4];
        OP_XOR:  node[WIN+m] = node[WIN+m-1] ^ node[WIN+m-4];
        default: node[WIN+m] = node[WIN+m-1] | node[WIN+m-4];
      endcase
    end
    for (int m = 0; m < WIN; m++) begin
      next_win[m] = node[NODE_COUNT+m];
    end
  end

endmodule

// File: rtl/logic_chain_pipe.sv
// logic_chain_pipe
//   Pipelined W-lane logic-chain evaluator with valid/ready handshake.
//   Nodes n1..n9 and the first recurrence group are computed from the
//   operands; each later group sits behind its own window register. A final
//   register holds y1..y5. Every register advances together on
//   en = ~out_valid | out_ready, so bubbles are carried, not collapsed.
//   Ports:
//     clk, rst_n          clock (rising) / asynchronous active-low reset
//     flush               synchronous clear of all valid bits
//     in_valid, in_ready  input handshake (in_ready = en)
//     a..j                W-bit operand vectors
//     out_valid, out_ready output handshake
//     y1..y5              W-bit results, held while stalled
module logic_chain_pipe
  import logic_chain_pkg::*;
#(
  parameter int W               = 1,
  parameter int CHAIN_LEN       = 30,
  parameter int NODES_PER_STAGE = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [W-1:0] e,
  input  logic [W-1:0] f,
  input  logic [W-1:0] g,
  input  logic [W-1:0] h,
  input  logic [W-1:0] i,
  input  logic [W-1:0] j,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [W-1:0] y4,
  output logic [W-1:0] y5
);

  localparam int NS = num_stages(CHAIN_LEN, NODES_PER_STAGE);

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Fixed front of the chain, straight from the operands.
  logic [W-1:0] n1, n2, n3, n4, n5, n6, n7, n8, n9;
  assign n1 = a & b;
  assign n2 = ~(c | d);
  assign n3 = e ^ f;
  assign n4 = g & h;
  assign n5 = ~(i | j);
  assign n6 = n1 | n2;
  assign n7 = n3 & n4;
  assign n8 = n5 ^ n6;
  assign n9 = n7 | n8;

  logic [WIN-1:0][W-1:0] head_win;
  assign head_win = {n9, n8, n7, n6, n5};

  logic [WIN-1:0][W-1:0] stage_next [NS];
  logic [WIN-1:0][W-1:0] win_p      [NS];
  logic [NS-1:0]         vld_p;

  for (genvar s = 0; s < NS; s++) begin : g_stage
    logic [WIN-1:0][W-1:0] prev_w;
    if (s == 0) begin : g_head
      assign prev_w = head_win;
    end else begin : g_body
      assign prev_w = win_p[s-1];
    end
    logic_chain_stage #(
      .W          (W),
      .FIRST_NODE (group_first(NODES_PER_STAGE, s)),
      .NODE_COUNT (group_count(CHAIN_LEN, NODES_PER_STAGE, s))
    ) u_stage (
      .prev_win (prev_w),
      .next_win (stage_next[s])
    );
  end

  // Output formula on the last window: [4]=n_L .. [0]=n_{L-4}.
  logic [WIN-1:0][W-1:0] tail_win;
  logic [W-1:0]          y1_next, y2_next, y3_next, y4_next, y5_next;
  assign tail_win = win_p[NS-1];
  assign y1_next  = tail_win[4] ^ tail_win[1];
  assign y2_next  = tail_win[2] | tail_win[3];
  assign y3_next  = tail_win[4] & tail_win[1];
  assign y4_next  = tail_win[2] ^ tail_win[0];
  assign y5_next  = tail_win[3] | tail_win[1];

  // ---- stage registers p0..p(NS-1) and output register: valid bits ----
  // flush wins over both an accept and a held output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      vld_p     <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      vld_p[0] <= in_valid;
      for (int s = 1; s < NS; s++) begin
        vld_p[s] <= vld_p[s-1];
      end
      out_valid <= vld_p[NS-1];
    end
  end

  // ---- stage registers p0..p(NS-1) and output register: data ----
  // Data moves on en regardless of validity; invalid slots carry stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin
        win_p[s] <= '0;
      end
      y1 <= '0;
      y2 <= '0;
      y3 <= '0;
      y4 <= '0;
      y5 <= '0;
    end else if (en) begin
      for (int s = 0; s < NS; s++) begin
        win_p[s] <= stage_next[s];
      end
      y1 <= y1_next;
      y2 <= y2_next;
      y3 <= y3_next;
      y4 <= y4_next;
      y5 <= y5_next;
    end
  end

endmodule

// File: tb/tb_logic_chain_pipe.sv
// Bench for logic_chain_pipe: three instances (default, L=13/NPS=1,
// NPS=21) share stimulus; each has its own expected-result FIFO filled
// from a plain node-by-node reference of the chain.
module tb_logic_chain_pipe;

  localparam int W   = 2;
  localparam int ND  = 3;
  localparam int OPW = 10 * W;
  localparam int LS  [ND] = '{30, 13, 30};
  localparam int NPS [ND] = '{7, 1, 21};
  localparam int LAT [ND] = '{4, 5, 2};

  typedef logic [5*W-1:0] res_t;
  // {y5,y4,y3,y2,y1} for lane0 e=g=h=1, lane1 e=g=h=i=1, default chain
  localparam res_t PAT_EXP = 10'b11_10_00_11_11;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic           in_valid;
  logic           out_ready;
  logic [OPW-1:0] ops;

  logic         in_ready_w  [ND];
  logic         out_valid_w [ND];
  logic [W-1:0] y1_w [ND];
  logic [W-1:0] y2_w [ND];
  logic [W-1:0] y3_w [ND];
  logic [W-1:0] y4_w [ND];
  logic [W-1:0] y5_w [ND];
  res_t         y_obs [ND];

  always #5 clk = ~clk;

  for (genvar k = 0; k < ND; k++) begin : g_dut
    logic_chain_pipe #(
      .W               (W),
      .CHAIN_LEN       (LS[k]),
      .NODES_PER_STAGE (NPS[k])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[k]),
      .a         (ops[0*W +: W]),
      .b         (ops[1*W +: W]),
      .c         (ops[2*W +: W]),
      .d         (ops[3*W +: W]),
      .e         (ops[4*W +: W]),
      .f         (ops[5*W +: W]),
      .g         (ops[6*W +: W]),
      .h         (ops[7*W +: W]),
      .i         (ops[8*W +: W]),
      .j         (ops[9*W +: W]),
      .out_valid (out_valid_w[k]),
      .out_ready (out_ready),
      .y1        (y1_w[k]),
      .y2        (y2_w[k]),
      .y3        (y3_w[k]),
      .y4        (y4_w[k]),
      .y5        (y5_w[k])
    );
    assign y_obs[k] = {y5_w[k], y4_w[k], y3_w[k], y2_w[k], y1_w[k]};
  end

  int   n_assert;
  int   n_fail;
  res_t fifo [ND][256];
  int   head [ND];
  int   tail [ND];
  int   pops [ND];
  int   pushes [ND];
  int   p0 [ND];
  int   q0 [ND];
  int   cnt [ND];
  int   lat [ND];
  logic stall_prev [ND];
  res_t y_prev [ND];
  int   edges;

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // Evaluate the chain node by node straight from the node definitions.
  function automatic res_t ref_model(input int L, input logic [OPW-1:0] v);
    logic [W-1:0] n [256];
    res_t r;
    n[1] = v[0*W +: W] & v[1*W +: W];
    n[2] = ~(v[2*W +: W] | v[3*W +: W]);
    n[3] = v[4*W +: W] ^ v[5*W +: W];
    n[4] = v[6*W +: W] & v[7*W +: W];
    n[5] = ~(v[8*W +: W] | v[9*W +: W]);
    n[6] = n[1] | n[2];
    n[7] = n[3] & n[4];
    n[8] = n[5] ^ n[6];
    n[9] = n[7] | n[8];
    for (int k = 10; k <= L; k++) begin
      case (k % 3)
        1:       n[k] = n[k-1] & n[k-4];
        2:       n[k] = n[k-1] ^ n[k-4];
        default: n[k] = n[k-1] | n[k-4];
      endcase
    end
    r[0*W +: W] = n[L] ^ n[L-3];
    r[1*W +: W] = n[L-2] | n[L-1];
    r[2*W +: W] = n[L] & n[L-3];
    r[3*W +: W] = n[L-2] ^ n[L-4];
    r[4*W +: W] = n[L-1] | n[L-3];
    return r;
  endfunction

  // Sample at the falling edge, update the transaction model, then step
  // past the next rising edge.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      if (!rst_n) begin
        head[k] = 0;
        tail[k] = 0;
        stall_prev[k] = 1'b0;
      end else begin
        if (stall_prev[k]) begin
          check("hold_valid", k, 32'(out_valid_w[k]), 32'd1);
          check("hold_y", k, 32'(y_obs[k]), 32'(y_prev[k]));
        end
        check("in_ready", k, 32'(in_ready_w[k]), 32'(!out_valid_w[k] || out_ready));
        if (tail[k] == head[k]) begin
          check("spurious_valid", k, 32'(out_valid_w[k]), 32'd0);
        end else if (out_valid_w[k] && out_ready) begin
          check("y", k, 32'(y_obs[k]), 32'(fifo[k][head[k] % 256]));
          head[k]++;
          pops[k]++;
        end
        if (flush) begin
          head[k] = tail[k];
        end else if (in_valid && in_ready_w[k]) begin
          fifo[k][tail[k] % 256] = ref_model(LS[k], ops);
          tail[k]++;
          pushes[k]++;
        end
        stall_prev[k] = out_valid_w[k] && !out_ready && !flush;
        y_prev[k] = y_obs[k];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int k = 0; k < ND; k++) begin
      head[k] = 0; tail[k] = 0; pops[k] = 0; pushes[k] = 0;
      stall_prev[k] = 1'b0; y_prev[k] = '0; lat[k] = 0; cnt[k] = 0;
    end
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ops = '0;

    // Reset held with random inputs
    for (int t = 0; t < 4; t++) begin
      ops = OPW'($urandom);
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
      for (int k = 0; k < ND; k++) begin
        check("rst_out_valid", k, 32'(out_valid_w[k]), 32'd0);
        check("rst_y", k, 32'(y_obs[k]), 32'd0);
        check("rst_in_ready", k, 32'(in_ready_w[k]), 32'd1);
      end
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      for (int k = 0; k < ND; k++) check("post_rst_valid", k, 32'(out_valid_w[k]), 32'd0);
    end

    // Directed lane pattern and latency
    ops = '0;
    ops[4*W +: W] = 2'b11;
    ops[6*W +: W] = 2'b11;
    ops[7*W +: W] = 2'b11;
    ops[8*W +: W] = 2'b10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    edges = 1;
    for (int t = 0; t < 8; t++) begin
      tick();
      edges++;
      for (int k = 0; k < ND; k++) begin
        if (lat[k] == 0 && out_valid_w[k]) begin
          lat[k] = edges;
          if (k == 0) check("lane_pattern", 0, 32'(y_obs[0]), 32'(PAT_EXP));
        end
      end
    end
    for (int k = 0; k < ND; k++) check("latency", k, lat[k], LAT[k]);

    // Streaming: 20 back-to-back beats
    for (int k = 0; k < ND; k++) p0[k] = pops[k];
    in_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      ops = OPW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    for (int k = 0; k < ND; k++) check("stream_count", k, pops[k] - p0[k], 20);

    // Backpressure: 5 stalled cycles with the pipeline full
    for (int k = 0; k < ND; k++) begin p0[k] = pops[k]; q0[k] = pushes[k]; end
    in_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      ops = OPW'($urandom);
      tick();
    end
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      ops = OPW'($urandom);
      #1;
      for (int k = 0; k < ND; k++) check("bp_in_ready", k, 32'(in_ready_w[k]), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      ops = OPW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < ND; k++) check("bp_count", k, pops[k] - p0[k], pushes[k] - q0[k]);

    // Flush with 3 beats in flight plus a simultaneous accept
    for (int t = 0; t < 3; t++) begin
      ops = OPW'($urandom);
      in_valid = 1'b1;
      tick();
    end
    ops = OPW'($urandom);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < ND; k++) cnt[k] = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      for (int k = 0; k < ND; k++) if (out_valid_w[k]) cnt[k]++;
    end
    for (int k = 0; k < ND; k++) check("flush_outputs", k, cnt[k], 0);

    // Random traffic with backpressure and occasional flush
    for (int t = 0; t < 300; t++) begin
      ops = OPW'($urandom);
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      flush = ($urandom_range(31) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    for (int k = 0; k < ND; k++) check("drain_empty", k, tail[k] - head[k], 0);

    // Reset in the middle of traffic
    in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      ops = OPW'($urandom);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      check("midrst_valid", k, 32'(out_valid_w[k]), 32'd0);
      check("midrst_y", k, 32'(y_obs[k]), 32'd0);
      check("midrst_in_ready", k, 32'(in_ready_w[k]), 32'd1);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < ND; k++) cnt[k] = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      for (int k = 0; k < ND; k++) if (out_valid_w[k]) cnt[k]++;
    end
    for (int k = 0; k < ND; k++) check("midrst_outputs", k, cnt[k], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_chain_pipe.md
Name: logic_chain_pipe

Overview:
- Pipelined, parametrised successor of the 10-input / 5-output combinational logic-chain benchmark.
- Evaluates the same node recurrence bitwise over W independent lanes, with configurable chain length and pipeline cut spacing.
- Adds a valid/ready handshake with backpressure and a synchronous flush.
- Sits as a registered datapath block in the synthesis-benchmark suite, giving ABC a sequential mapping and retiming case.

Parameters:
- W, 1, lane count; every data port is W bits and lanes are fully independent.
- CHAIN_LEN, 30, index L of the last node; legal range 13..255.
- NODES_PER_STAGE, 7, recurrence nodes computed between pipeline registers; legal range 1..L-9.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all valid bits.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat.
- a,b,c,d,e,f,g,h,i,j  in  W each  operand vectors.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- y1,y2,y3,y4,y5  out  W each  results.

Behaviour:
- Node definitions (bitwise per lane):
  - n1=a&b, n2=~(c|d), n3=e^f, n4=g&h, n5=~(i|j)
  - n6=n1|n2, n7=n3&n4, n8=n5^n6, n9=n7|n8
  - For k=10..L: n_k = op(n_{k-1}, n_{k-4}), where op is AND if k mod 3=1, XOR if k mod 3=2, OR if k mod 3=0.
- Outputs (with L = CHAIN_LEN):
  - y1=n_L ^ n_{L-3}
  - y2=n_{L-2} | n_{L-1}
  - y3=n_L & n_{L-3}
  - y4=n_{L-2} ^ n_{L-4}
  - y5=n_{L-1} | n_{L-3}
- Stage structure:
  - Nodes 10..L are split into NS=ceil((L-9)/NODES_PER_STAGE) groups; the last group may be short.
  - Stage 1 computes n1..n9 plus group 1 directly from the inputs.
  - Each stage register holds a 5-node window (the newest five node values, W bits each) and a valid bit. A 5-node window is enough for both the k-4 recurrence and the y4 term.
  - A final output register holds y1..y5 and out_valid.
- Latency: a beat accepted at edge T appears on the outputs after edge T+NS; out_valid is high in that cycle. Default latency is 3 register stages plus the output register = 4 edges.
- Handshake and stall:
  - Global advance enable en = ~out_valid | out_ready.
  - in_ready = en, combinational; there is no combinational path from in_valid to in_ready.
  - A beat is accepted when in_valid & in_ready.
  - When en=1, every stage register shifts forward, including bubbles; internal bubbles are not collapsed.
  - When en=0, all registers hold, including y and out_valid. y must be stable while out_valid & ~out_ready.
  - Data registers load only on en. An invalid slot may carry stale data.
- Throughput: one beat per cycle with out_ready held high.
- flush:
  - Clears every valid bit (stages and out_valid) at the next edge; data registers are untouched.
  - Overrides a simultaneous accept: that beat is dropped.
  - Overrides a stall: a held output is discarded.
- Reset (rst_n low, asynchronous):
  - All valid bits, windows and y1..y5 go to 0.
  - in_ready is 1 after reset because out_valid=0.
  - Reset mid-operation discards all in-flight beats.
  - Deassertion is synchronised externally.
- Boundary when NODES_PER_STAGE ≥ L-9: NS=1, latency 2 edges.

Decomposition:
- Package logic_chain_pkg holds:
  - the op-select function (k mod 3 → AND/XOR/OR)
  - the NS computation function
  - the window depth constant WIN=5
- One sub-module, logic_chain_stage, is parametrised by first node index and node count. It takes a window in and produces a window out, is purely combinational, and is instantiated NS times by a generate loop.
- The top level owns the registers, handshake and output formula.

Test Plan:
- Reset: hold rst_n=0 with random inputs → out_valid=0, y1..y5=0, in_ready=1; release, no spurious out_valid.
- Default parameters, W=1: e=g=h=1, others 0, one beat → after 4 edges out_valid=1, y1..y5=1,1,0,0,1.
- W=2 lane independence: lane0 e=g=h=1; lane1 e=g=h=i=1, rest 0 → y1=2'b11, y2=2'b11, y3=2'b00, y4=2'b10, y5=2'b11.
- Streaming: 20 back-to-back random beats with out_ready=1 → 20 outputs in order, one per cycle, each matching the reference model.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 → in_ready=0, y stable, no beat lost or duplicated after release.
- Flush and parameter sweep:
  - flush asserted with 3 beats in flight and a simultaneous accept → 0 outputs emerge.
  - Repeat the streaming check with CHAIN_LEN=13, NODES_PER_STAGE=1 (latency 5 edges).
  - Repeat it with NODES_PER_STAGE=21 (NS=1, latency 2 edges).
